universal_shift_register: RTL and testbench
===========================================

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the register width in bits (legal range 2..64).
REQ-002 Derived localparam CNT_W, default $clog2(WIDTH+1), SHALL set the shift-count width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 load  input  1  SHALL parallel-load data_in.
REQ-006 data_in  input  WIDTH  SHALL be the parallel load value.
REQ-007 shift  input  1  SHALL request one manual shift step in the current mode.
REQ-008 mode  input  3  SHALL select the operation: 000 logical right, 001 logical left, 010 rotate right, 011 rotate left, 100 arithmetic right; 101-111 hold.
REQ-009 ser_in  input  1  SHALL be the serial fill bit for logical shifts.
REQ-010 start  input  1  SHALL request an automatic multi-step shift sequence.
REQ-011 shift_cnt  input  CNT_W  SHALL be the step count for the sequence.
REQ-012 data_out  output  WIDTH  SHALL be the register contents.
REQ-013 ser_out  output  1  SHALL be the bit ejected by the most recent shift step.
REQ-014 busy  output  1  SHALL be high while an automatic sequence runs.
REQ-015 done  output  1  SHALL pulse high for one cycle when a sequence completes.

Function
REQ-016 One step SHALL be: right: {ser_in, q[W-1:1]}; left: {q[W-2:0], ser_in}; rotr: {q[0], q[W-1:1]}; rotl: {q[W-2:0], q[W-1]}; asr: {q[W-1], q[W-1:1]}.
REQ-017 ser_out SHALL take q[0] on right/rotr/asr steps and q[W-1] on left/rotl steps; it SHALL be unchanged on hold modes and on non-shift cycles.
REQ-018 Priority SHALL be rst > load > running sequence > manual shift > hold.
REQ-019 The FSM SHALL have states IDLE and RUN; reset SHALL enter IDLE.
REQ-020 In IDLE, start high with shift_cnt=N>0 (load low) SHALL latch mode and N and enter RUN; busy SHALL be high from the following cycle.
REQ-021 In RUN one step SHALL occur per cycle; after the Nth step the FSM SHALL return to IDLE, busy SHALL drop, and done SHALL be high for exactly the next cycle.
REQ-022 Latency: start sampled at edge k SHALL give steps at edges k+1..k+N and done high in the cycle after edge k+N.
REQ-023 start with shift_cnt=0 SHALL make no step, keep busy low, and pulse done in the next cycle.
REQ-024 mode changes during RUN SHALL be ignored (latched mode used); ser_in SHALL be sampled live on each step.
REQ-025 start or shift while busy SHALL be ignored.
REQ-026 load during RUN SHALL abort: data_out=data_in, FSM to IDLE, busy low, no done pulse.
REQ-027 load and start in the same cycle SHALL perform the load only.
REQ-028 shift_cnt values above WIDTH SHALL be honoured literally (no saturation).

Reset
REQ-029 rst SHALL force data_out=0, ser_out=0, busy=0, done=0, FSM=IDLE, internal counter=0 at the next clock edge, overriding any sequence in progress.

Structure
REQ-030 Mode encodings SHALL be constants in shared package usr_pkg.
REQ-031 The single-step next-value logic SHALL be one combinational sub-module usr_step, shared by manual and sequenced paths.

Verification
REQ-032 Reset: rst high 1 cycle -> data_out=0, ser_out=0, busy=0, done=0.
REQ-033 WIDTH=4, load 4'b1011, mode 000, ser_in 0, shift 4 cycles -> data_out 0101, 0010, 0001, 0000; ser_out 1, 1, 0, 1.
REQ-034 WIDTH=8, load 8'h96, mode 100, start cnt 3 -> busy 3 cycles, data_out 8'hF2, done one cycle after the last step.
REQ-035 WIDTH=8, load 8'h81, mode 011, start cnt 8 -> data_out 8'h81 after 8 steps, done pulses once.
REQ-036 WIDTH=8, load 8'hFF, mode 001, ser_in 0, start cnt 5, load 8'h3C after 2 steps -> data_out 8'h3C, busy 0, no done.
REQ-037 start cnt 0 with data 8'h5A -> done next cycle, busy never high, data_out stays 8'h5A.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared constants for the universal shift register: mode encodings and FSM states.
package usr_pkg;

  localparam logic [2:0] MODE_SHR = 3'b000;  // logical right
  localparam logic [2:0] MODE_SHL = 3'b001;  // logical left
  localparam logic [2:0] MODE_ROR = 3'b010;  // rotate right
  localparam logic [2:0] MODE_ROL = 3'b011;  // rotate left
  localparam logic [2:0] MODE_ASR = 3'b100;  // arithmetic right
  // Encodings 101..111 are hold.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/universal_shift_register_if.sv
// Control and data bundle of the universal shift register.
// The master side drives commands; the slave side (the register) returns state.
interface universal_shift_register_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             shift;
  logic [2:0]       mode;
  logic             ser_in;
  logic             start;
  logic [CNT_W-1:0] shift_cnt;
  logic [WIDTH-1:0] data_out;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output load, data_in, shift, mode, ser_in, start, shift_cnt,
    input  data_out, ser_out, busy, done
  );

  modport slave (
    input  load, data_in, shift, mode, ser_in, start, shift_cnt,
    output data_out, ser_out, busy, done
  );
endinterface

// File: rtl/usr_step.sv
// Single-step next-value logic, shared by the manual and sequenced shift paths.
// valid is low for the hold encodings; q_next then equals q.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q_next,
  output logic             ser_bit,
  output logic             valid
);

  // Compute one shift step and the bit it ejects.
  always_comb begin
    q_next  = q;
    ser_bit = 1'b0;
    valid   = 1'b0;
    case (mode)
      MODE_SHR: begin
        q_next  = {ser_in, q[WIDTH-1:1]};
        ser_bit = q[0];
        valid   = 1'b1;
      end
      MODE_SHL: begin
        q_next  = {q[WIDTH-2:0], ser_in};
        ser_bit = q[WIDTH-1];
        valid   = 1'b1;
      end
      MODE_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        ser_bit = q[0];
        valid   = 1'b1;
      end
      MODE_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        ser_bit = q[WIDTH-1];
        valid   = 1'b1;
      end
      MODE_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        ser_bit = q[0];
        valid   = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with parallel load, manual single steps and an
// automatic N-step sequence (IDLE/RUN FSM) with busy/done status.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  universal_shift_register_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lmode_q, lmode_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;
  logic             step_valid;

  // The running sequence uses the latched mode; otherwise the live mode.
  assign step_mode = (state_q == ST_RUN) ? lmode_q : bus.mode;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_q),
    .mode    (step_mode),
    .ser_in  (bus.ser_in),
    .q_next  (step_q),
    .ser_bit (step_bit),
    .valid   (step_valid)
  );

  // Next-state and datapath selection: load > running sequence > start > manual shift.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    done_d  = 1'b0;
    if (bus.load) begin
      // Load aborts a running sequence without a done pulse.
      q_d     = bus.data_in;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      q_d   = step_q;
      if (step_valid) so_d = step_bit;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (bus.start) begin
      if (bus.shift_cnt == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        cnt_d   = bus.shift_cnt;
        lmode_d = bus.mode;
      end
    end else if (bus.shift && step_valid) begin
      q_d  = step_q;
      so_d = step_bit;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      lmode_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      lmode_q <= lmode_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out = q_q;
  assign bus.ser_out  = so_q;
  assign bus.busy     = (state_q == ST_RUN);
  assign bus.done     = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register at WIDTH=4 and WIDTH=8.
module tb_universal_shift_register;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  universal_shift_register_if #(.WIDTH(4)) b4();
  universal_shift_register_if #(.WIDTH(8)) b8();

  universal_shift_register #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  universal_shift_register #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));

  int nerr = 0;
  int nchk = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [63:0] q;
    logic        so;
    logic        busy;
    logic        done;
    int unsigned rem;
    logic [2:0]  lm;
  } mdl_t;
  mdl_t m [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One shift step by arithmetic on a w-bit value.
  function automatic logic [63:0] mstep(input logic [63:0] q, input logic [2:0] md,
                                        input logic s, input int unsigned w,
                                        output logic ej, output logic ok);
    logic [63:0] mask, top;
    mask = (64'd1 << w) - 64'd1;
    top  = 64'd1 << (w - 1);
    ok = 1'b1;
    ej = 1'b0;
    case (md)
      3'd0: begin ej = q[0]; return (q >> 1) | (s ? top : 64'd0); end
      3'd1: begin ej = (q & top) != 0; return ((q << 1) | 64'(s)) & mask; end
      3'd2: begin ej = q[0]; return (q >> 1) | (q[0] ? top : 64'd0); end
      3'd3: begin ej = (q & top) != 0; return ((q << 1) | 64'(ej)) & mask; end
      3'd4: begin ej = q[0]; return (q >> 1) | (q & top); end
      default: begin ok = 1'b0; return q; end
    endcase
  endfunction

  task automatic mupd(input int i, input int unsigned w, input logic r, input logic ld,
                      input logic [63:0] din, input logic sh, input logic [2:0] md,
                      input logic s, input logic st, input int unsigned cnt);
    logic ej, ok;
    logic [63:0] nq;
    if (r) begin
      m[i].q = 0; m[i].so = 0; m[i].busy = 0; m[i].done = 0; m[i].rem = 0; m[i].lm = 0;
      return;
    end
    m[i].done = 1'b0;
    if (ld) begin
      m[i].q = din; m[i].busy = 1'b0; m[i].rem = 0;
    end else if (m[i].busy) begin
      nq = mstep(m[i].q, m[i].lm, s, w, ej, ok);
      m[i].q = nq;
      if (ok) m[i].so = ej;
      m[i].rem--;
      if (m[i].rem == 0) begin m[i].busy = 1'b0; m[i].done = 1'b1; end
    end else if (st) begin
      if (cnt == 0) m[i].done = 1'b1;
      else begin m[i].busy = 1'b1; m[i].rem = cnt; m[i].lm = md; end
    end else if (sh) begin
      nq = mstep(m[i].q, md, s, w, ej, ok);
      if (ok) begin m[i].q = nq; m[i].so = ej; end
    end
  endtask

  // Advance the model on every rising edge from the same inputs the DUTs see.
  always @(posedge clk) begin
    mupd(0, 4, rst, b4.load, 64'(b4.data_in), b4.shift, b4.mode, b4.ser_in, b4.start,
         int'(b4.shift_cnt));
    mupd(1, 8, rst, b8.load, 64'(b8.data_in), b8.shift, b8.mode, b8.ser_in, b8.start,
         int'(b8.shift_cnt));
  end

  // Compare both DUTs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m4_data", 64'(b4.data_out), m[0].q);
      chk("m4_so",   64'(b4.ser_out),  64'(m[0].so));
      chk("m4_busy", 64'(b4.busy),     64'(m[0].busy));
      chk("m4_done", 64'(b4.done),     64'(m[0].done));
      chk("m8_data", 64'(b8.data_out), m[1].q);
      chk("m8_so",   64'(b8.ser_out),  64'(m[1].so));
      chk("m8_busy", 64'(b8.busy),     64'(m[1].busy));
      chk("m8_done", 64'(b8.done),     64'(m[1].done));
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic l8(input string n, input logic [7:0] d, input logic bz, input logic dn);
    chk({n, "_data"}, 64'(b8.data_out), 64'(d));
    chk({n, "_busy"}, 64'(b8.busy), 64'(bz));
    chk({n, "_done"}, 64'(b8.done), 64'(dn));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b4.load = 0; b4.data_in = '0; b4.shift = 0; b4.mode = '0; b4.ser_in = 0;
    b4.start = 0; b4.shift_cnt = '0;
    b8.load = 0; b8.data_in = '0; b8.shift = 0; b8.mode = '0; b8.ser_in = 0;
    b8.start = 0; b8.shift_cnt = '0;
    @(negedge clk);
    tick;
    chk_en = 1'b1;
    l8("rst8", 8'h00, 1'b0, 1'b0);
    chk("rst8_so", 64'(b8.ser_out), 64'd0);
    chk("rst4_data", 64'(b4.data_out), 64'd0);
    chk("rst4_so", 64'(b4.ser_out), 64'd0);
    rst = 1'b0;

    // WIDTH=4 logical right with ser_in=0
    b4.load = 1; b4.data_in = 4'b1011; tick;
    b4.load = 0; b4.mode = 3'b000; b4.ser_in = 0; b4.shift = 1;
    tick; chk("r4_d1", 64'(b4.data_out), 64'b0101); chk("r4_s1", 64'(b4.ser_out), 64'd1);
    tick; chk("r4_d2", 64'(b4.data_out), 64'b0010); chk("r4_s2", 64'(b4.ser_out), 64'd1);
    tick; chk("r4_d3", 64'(b4.data_out), 64'b0001); chk("r4_s3", 64'(b4.ser_out), 64'd0);
    tick; chk("r4_d4", 64'(b4.data_out), 64'b0000); chk("r4_s4", 64'(b4.ser_out), 64'd1);
    b4.shift = 0;

    // Arithmetic right sequence of 3; mode/start/shift changes mid-run ignored
    b8.load = 1; b8.data_in = 8'h96; tick;
    b8.load = 0; b8.mode = 3'b100; b8.start = 1; b8.shift_cnt = 3;
    tick; l8("asr_k", 8'h96, 1'b1, 1'b0);
    b8.mode = 3'b011; b8.shift_cnt = 1; b8.shift = 1;
    tick; l8("asr_1", 8'hCB, 1'b1, 1'b0);
    b8.start = 0; b8.shift = 0;
    tick; l8("asr_2", 8'hE5, 1'b1, 1'b0);
    tick; l8("asr_3", 8'hF2, 1'b0, 1'b1);
    tick; l8("asr_4", 8'hF2, 1'b0, 1'b0);

    // Rotate left by full width returns the original value
    b8.load = 1; b8.data_in = 8'h81; tick;
    b8.load = 0; b8.mode = 3'b011; b8.start = 1; b8.shift_cnt = 8;
    tick; b8.start = 0;
    repeat (7) tick;
    l8("rol_7", 8'hC0, 1'b1, 1'b0);
    tick; l8("rol_8", 8'h81, 1'b0, 1'b1);
    tick; l8("rol_9", 8'h81, 1'b0, 1'b0);

    // Count above WIDTH honoured; ser_in sampled live each step
    b8.load = 1; b8.data_in = 8'h00; tick;
    b8.load = 0; b8.mode = 3'b000; b8.ser_in = 1; b8.start = 1; b8.shift_cnt = 10;
    tick; b8.start = 0;
    repeat (5) tick;
    l8("cnt_5", 8'hF8, 1'b1, 1'b0);
    b8.ser_in = 0;
    repeat (4) tick;
    l8("cnt_9", 8'h0F, 1'b1, 1'b0);
    tick; l8("cnt_10", 8'h07, 1'b0, 1'b1);
    chk("cnt_so", 64'(b8.ser_out), 64'd1);

    // Load aborts a running sequence with no done pulse
    b8.load = 1; b8.data_in = 8'hFF; tick;
    b8.load = 0; b8.mode = 3'b001; b8.ser_in = 0; b8.start = 1; b8.shift_cnt = 5;
    tick; b8.start = 0;
    tick; tick; l8("abt_2", 8'hFC, 1'b1, 1'b0);
    b8.load = 1; b8.data_in = 8'h3C;
    tick; l8("abt_ld", 8'h3C, 1'b0, 1'b0);
    b8.load = 0;
    tick; l8("abt_after", 8'h3C, 1'b0, 1'b0);

    // Zero-length sequence
    b8.load = 1; b8.data_in = 8'h5A; tick;
    b8.load = 0; b8.start = 1; b8.shift_cnt = 0;
    tick; l8("z_1", 8'h5A, 1'b0, 1'b1);
    b8.start = 0;
    tick; l8("z_2", 8'h5A, 1'b0, 1'b0);

    // Load and start together: load only
    b8.load = 1; b8.data_in = 8'h33; b8.start = 1; b8.shift_cnt = 3; b8.mode = 3'b000;
    tick; l8("ls_1", 8'h33, 1'b0, 1'b0);
    b8.load = 0; b8.start = 0;
    tick; l8("ls_2", 8'h33, 1'b0, 1'b0);

    // Manual steps: hold mode, rotate right, arithmetic right, logical right with fill 1
    b8.mode = 3'b101; b8.ser_in = 1; b8.shift = 1;
    tick; chk("hold_d", 64'(b8.data_out), 64'h33);
    b8.mode = 3'b010;
    tick; chk("ror_d", 64'(b8.data_out), 64'h99); chk("ror_s", 64'(b8.ser_out), 64'd1);
    b8.mode = 3'b100;
    tick; chk("asrm_d", 64'(b8.data_out), 64'hCC); chk("asrm_s", 64'(b8.ser_out), 64'd1);
    b8.mode = 3'b000;
    tick; chk("shr1_d", 64'(b8.data_out), 64'hE6); chk("shr1_s", 64'(b8.ser_out), 64'd0);
    b8.shift = 0;

    // Reset overrides a running sequence
    b8.mode = 3'b001; b8.start = 1; b8.shift_cnt = 5;
    tick; b8.start = 0;
    tick; tick;
    rst = 1'b1;
    tick; l8("rrun", 8'h00, 1'b0, 1'b0);
    chk("rrun_so", 64'(b8.ser_out), 64'd0);
    rst = 1'b0;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
